drivetrain_model: RTL



---
 rtl/drivetrain_model.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/drivetrain_model.sv
// drivetrain_model: tick-driven vehicle drivetrain for the dashboard datapath.
// Converts throttle/brake/shift commands into speed, engine rpm and engaged gear.
// Models per-gear acceleration, braking and speed caps, rpm slew limiting, a timed
// shift/clutch sequence with request rejection, a hysteretic rev limiter and
// neutral free-revving.
module drivetrain_model #(
  parameter int NUM_GEARS = 6,
  parameter int SPEED_W = 9,
  parameter int RPM_W = 14,
  parameter int SPEED_MAX = 400,
  parameter logic [79:0] GEAR_RATIO = {10'd0, 10'd72, 10'd83, 10'd100,
                                       10'd141, 10'd219, 10'd360, 10'd0},
  parameter logic [8*SPEED_W-1:0] GEAR_VMAX = {SPEED_W'(0), SPEED_W'(400), SPEED_W'(300),
                                               SPEED_W'(200), SPEED_W'(130), SPEED_W'(70),
                                               SPEED_W'(30), SPEED_W'(0)},
  parameter logic [31:0] ACCEL_STEP = {4'd0, 4'd6, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd0},
  parameter logic [31:0] BRAKE_STEP = {4'd0, 4'd8, 4'd7, 4'd7, 4'd6, 4'd5, 4'd4, 4'd8},
  parameter int RPM_K = 36367,
  parameter int IDLE_RPM = 800,
  parameter int OVERLOAD_RPM = 7000,
  parameter int RPM_LIMIT = 8000,
  parameter int LIMITER_HYST = 500,
  parameter int RPM_SLEW = 500,
  parameter int SHIFT_TICKS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               throttle,
  input  logic               brake,
  input  logic               shift_req,
  input  logic [2:0]         gear_cmd,
  output logic [SPEED_W-1:0] speed_kmh,
  output logic [RPM_W-1:0]   rpm,
  output logic [2:0]         gear,
  output logic               shifting,
  output logic               shift_reject,
  output logic               limiter_active,
  output logic               overload
);

  typedef enum logic {DRIVE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int CNT_W = (SHIFT_TICKS < 2) ? 1 : $clog2(SHIFT_TICKS);

  localparam logic [SPEED_W-1:0]      SPEED_CAP = SPEED_W'(SPEED_MAX);
  localparam logic [RPM_W-1:0]        IDLE_V    = RPM_W'(IDLE_RPM);
  localparam logic [RPM_W-1:0]        LIMIT_V   = RPM_W'(RPM_LIMIT);
  localparam logic [RPM_W-1:0]        REARM_V   = RPM_W'(RPM_LIMIT - LIMITER_HYST);
  localparam logic [RPM_W-1:0]        OVL_V     = RPM_W'(OVERLOAD_RPM);
  localparam logic [RPM_W-1:0]        SLEW_V    = RPM_W'(RPM_SLEW);
  localparam logic signed [RPM_W+1:0] SLEW_S    = (RPM_W+2)'(RPM_SLEW);

  state_t             state;
  logic [CNT_W-1:0]   shift_cnt;
  logic [2:0]         pend_gear;

  logic               eff_thr;
  logic [SPEED_W-1:0] vmax_g;
  logic [SPEED_W-1:0] accel_cap;
  logic [SPEED_W-1:0] spd_raw;
  logic [SPEED_W-1:0] speed_nx;
  logic [RPM_W-1:0]   rpm_tgt;
  logic [RPM_W-1:0]   rpm_nx;
  logic               lim_nx;
  logic               accept;

  // Per-gear table lookups
  function automatic logic [SPEED_W-1:0] vmax_of(input logic [2:0] g);
    return GEAR_VMAX[int'(g)*SPEED_W +: SPEED_W];
  endfunction

  function automatic logic [9:0] ratio_of(input logic [2:0] g);
    return GEAR_RATIO[int'(g)*10 +: 10];
  endfunction

  function automatic logic [SPEED_W-1:0] accel_of(input logic [2:0] g);
    return SPEED_W'(ACCEL_STEP[int'(g)*4 +: 4]);
  endfunction

  function automatic logic [SPEED_W-1:0] brake_of(input logic [2:0] g);
    return SPEED_W'(BRAKE_STEP[int'(g)*4 +: 4]);
  endfunction

  // Speed decrement that floors at zero
  function automatic logic [SPEED_W-1:0] sat_sub(input logic [SPEED_W-1:0] a,
                                                 input logic [SPEED_W-1:0] b);
    logic signed [SPEED_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? '0 : d[SPEED_W-1:0];
  endfunction

  // Speed increment that saturates at cap
  function automatic logic [SPEED_W-1:0] sat_add(input logic [SPEED_W-1:0] a,
                                                 input logic [SPEED_W-1:0] b,
                                                 input logic [SPEED_W-1:0] cap);
    logic [SPEED_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, cap}) ? cap : s[SPEED_W-1:0];
  endfunction

  // Gear-locked rpm from road speed, truncated then clamped to [idle, limit]
  function automatic logic [RPM_W-1:0] gear_rpm(input logic [SPEED_W-1:0] s,
                                                 input logic [9:0] r);
    logic [47:0] prod;
    logic [47:0] q;
    prod = 48'(s) * 48'(RPM_K) * 48'(r);
    q = prod / 48'd100000;
    if (q < 48'(IDLE_RPM)) return IDLE_V;
    else if (q > 48'(RPM_LIMIT)) return LIMIT_V;
    else return q[RPM_W-1:0];
  endfunction

  // Move toward the target by at most one slew step, never overshooting
  function automatic logic [RPM_W-1:0] slew(input logic [RPM_W-1:0] cur,
                                            input logic [RPM_W-1:0] tgt);
    logic signed [RPM_W+1:0] diff;
    diff = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    if (diff > SLEW_S) return cur + SLEW_V;
    else if (diff < -SLEW_S) return cur - SLEW_V;
    else return tgt;
  endfunction

  // Next-tick speed, rpm and limiter, plus shift acceptance
  always_comb begin
    eff_thr   = throttle & ~limiter_active & (state == DRIVE);
    vmax_g    = vmax_of(gear);
    accel_cap = (vmax_g < SPEED_CAP) ? vmax_g : SPEED_CAP;

    if (brake)
      spd_raw = sat_sub(speed_kmh, brake_of(gear));
    else if (eff_thr && gear != 3'd0)
      spd_raw = sat_add(speed_kmh, accel_of(gear), accel_cap);
    else
      spd_raw = sat_sub(speed_kmh, SPEED_W'(1));

    speed_nx = (gear != 3'd0 && spd_raw > vmax_g) ? vmax_g : spd_raw;

    if (gear == 3'd0)
      rpm_tgt = eff_thr ? LIMIT_V : IDLE_V;
    else if (state == SHIFT)
      rpm_tgt = IDLE_V;
    else
      rpm_tgt = gear_rpm(speed_nx, ratio_of(gear));

    rpm_nx = slew(rpm, rpm_tgt);
    lim_nx = (rpm_nx >= LIMIT_V) | (limiter_active & (rpm_nx > REARM_V));

    accept = (gear_cmd == 3'd0) ||
             ((int'(gear_cmd) <= NUM_GEARS) && (gear_cmd != gear) &&
              (speed_kmh <= vmax_of(gear_cmd)));
  end

  // Registered vehicle state and the DRIVE/SHIFT sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= DRIVE;
      speed_kmh      <= '0;
      rpm            <= IDLE_V;
      gear           <= 3'd0;
      pend_gear      <= 3'd0;
      shifting       <= 1'b0;
      shift_reject   <= 1'b0;
      limiter_active <= 1'b0;
      shift_cnt      <= '0;
    end else begin
      shift_reject <= 1'b0;
      if (tick) begin
        speed_kmh      <= speed_nx;
        rpm            <= rpm_nx;
        limiter_active <= lim_nx;
      end
      case (state)
        DRIVE: begin
          if (shift_req) begin
            if (accept) begin
              pend_gear <= gear_cmd;
              state     <= SHIFT;
              shifting  <= 1'b1;
              shift_cnt <= '0;
            end else begin
              shift_reject <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (shift_req) shift_reject <= 1'b1;
          if (tick) begin
            if (shift_cnt == CNT_W'(SHIFT_TICKS - 1)) begin
              gear      <= pend_gear;
              state     <= DRIVE;
              shifting  <= 1'b0;
              shift_cnt <= '0;
            end else begin
              shift_cnt <= shift_cnt + 1'b1;
            end
          end
        end
        default: state <= DRIVE;
      endcase
    end
  end

  assign overload = (rpm >= OVL_V);

endmodule
